// File: rtl/pulse_bcd_display.sv
// Pulse event counter: synchronises a pulse input, counts its rising edges as a
// Digits-wide BCD value with a sticky overflow flag, and scans the live or frozen
// count onto a multiplexed 7-segment display.
module pulse_bcd_display #(
  parameter int unsigned Digits       = 4,
  parameter int unsigned ScanDiv      = 100000,
  parameter bit          SegActiveLow = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pulse_i,
  input  logic                  clr_i,
  input  logic                  hold_i,
  output logic [4*Digits-1:0]   count_bcd_o,
  output logic                  overflow_o,
  output logic [Digits-1:0]     an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o
);

  localparam int unsigned IdxW = (Digits > 1) ? $clog2(Digits) : 1;
  localparam int unsigned CntW = $clog2(ScanDiv);
  localparam logic [6:0]        SegZero = 7'h3f;
  localparam logic [6:0]        SegPol  = {7{SegActiveLow}};
  localparam logic [Digits-1:0] AnPol   = {Digits{SegActiveLow}};

  logic [2:0]          sync_q;
  logic                inc;
  logic [4*Digits-1:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                carry;
  logic                hold_q;
  logic [4*Digits-1:0] snap_q, shown;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [Digits-1:0]   blank;
  logic                zero_above;
  logic [3:0]          digit;
  logic [6:0]          seg_raw;
  logic [Digits-1:0]   an_raw;
  logic                dp_raw;
  logic [Digits-1:0]   an_q;
  logic [6:0]          seg_q;
  logic                dp_q;

  // Two-stage synchroniser followed by an edge-history flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], pulse_i};
  end

  assign inc = sync_q[1] & ~sync_q[2];

  // Ripple BCD increment; clear wins over a coincident increment.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    carry      = inc;
    for (int k = 0; k < int'(Digits); k++) begin
      if (carry) begin
        if (count_q[4*k+:4] == 4'd9) begin
          count_d[4*k+:4] = 4'd0;
        end else begin
          count_d[4*k+:4] = count_q[4*k+:4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    if (carry) overflow_d = 1'b1;
    if (clr_i) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // Count, overflow and hold-edge state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= 1'b0;
      snap_q     <= '0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_i;
      snap_q     <= shown;
    end
  end

  // First hold cycle still shows (and captures) the live count; later ones the snapshot.
  assign shown = (hold_i && hold_q) ? snap_q : count_q;

  // Scan slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntW'(ScanDiv - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxW'(Digits - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Leading-zero blanking: digit k>0 blank when it and everything above are zero.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int k = int'(Digits) - 1; k >= 0; k--) begin
      zero_above = zero_above & (shown[4*k+:4] == 4'd0);
      if (k != 0) blank[k] = zero_above;
    end
  end

  // Segment decode {g,f,e,d,c,b,a}, anode select and decimal point, active-high.
  always_comb begin
    digit = shown[4*idx_q+:4];
    unique case (digit)
      4'd0:    seg_raw = 7'h3f;
      4'd1:    seg_raw = 7'h06;
      4'd2:    seg_raw = 7'h5b;
      4'd3:    seg_raw = 7'h4f;
      4'd4:    seg_raw = 7'h66;
      4'd5:    seg_raw = 7'h6d;
      4'd6:    seg_raw = 7'h7d;
      4'd7:    seg_raw = 7'h07;
      4'd8:    seg_raw = 7'h7f;
      4'd9:    seg_raw = 7'h6f;
      default: seg_raw = 7'h00;
    endcase
    if (blank[idx_q]) seg_raw = 7'h00;
    an_raw        = '0;
    an_raw[idx_q] = 1'b1;
    dp_raw        = (idx_q == '0) && overflow_q;
  end

  // Output registers; polarity applied here only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_q    <= AnPol;
      an_q[0] <= ~SegActiveLow;
      seg_q   <= SegZero ^ SegPol;
      dp_q    <= SegActiveLow;
    end else begin
      an_q  <= an_raw ^ AnPol;
      seg_q <= seg_raw ^ SegPol;
      dp_q  <= dp_raw ^ SegActiveLow;
    end
  end

  assign count_bcd_o = count_q;
  assign overflow_o  = overflow_q;
  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign dp_o        = dp_q;

endmodule
